// File: rtl/uctl_ahbm_rd_fetch.sv
// AHB-Lite read master for the DMA Tx path: issues word-sized SINGLE reads for a
// byte-length request and buffers the returned words in a small show-ahead FIFO.
module uctl_ahbm_rd_fetch #(
  parameter int CNTR_WD    = 20,
  parameter int DATA_SIZE  = 32,
  parameter int ADDR_SIZE  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 core_Clk,
  input  logic                 uctl_reset,
  input  logic                 sw_rst,
  input  logic [ADDR_SIZE-1:0] dmaTx2ahbm_sRdAddr,
  input  logic [CNTR_WD-1:0]   dmaTx2ahbm_len,
  input  logic                 dmaTx2ahbm_stransEn,
  input  logic                 dmaTx2ahbm_sRdWr,
  // ready means the head word on wrData is valid; rd while ready consumes it in
  // that cycle, and rd while not ready is ignored.
  input  logic                 dmaTx2ahbm_rd,
  output logic                 ahbm2dmaTx_ready,
  output logic [DATA_SIZE-1:0] ahbm2dmaTx_wrData,
  output logic                 ahbm2dmaTx_dataDn,
  output logic                 ahbm2dmaTx_err,
  output logic [ADDR_SIZE-1:0] HADDR,
  output logic [1:0]           HTRANS,
  output logic [2:0]           HSIZE,
  output logic [2:0]           HBURST,
  output logic                 HWRITE,
  input  logic                 HREADY,
  input  logic [DATA_SIZE-1:0] HRDATA,
  input  logic [1:0]           HRESP,
  output logic [2:0]           fsm_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_WSPACE = 3'd3;
  localparam logic [2:0] S_FLUSH  = 3'd4;

  logic [2:0]           state, state_nxt;
  logic [ADDR_SIZE-1:0] addr_r;
  logic [CNTR_WD:0]     beats_r;
  logic [CNTR_WD:0]     beats_len;
  logic                 abort_pend;
  logic                 zero_dn_r;

  logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count, count_nxt;

  logic start_ok, data_ok, beat_err, push, pop, last, room;

  assign start_ok  = (state == S_IDLE) && dmaTx2ahbm_stransEn && !dmaTx2ahbm_sRdWr && !sw_rst;
  assign beats_len = ({1'b0, dmaTx2ahbm_len} + (CNTR_WD+1)'(3)) >> 2;
  assign data_ok   = (state == S_DATA) && HREADY && !sw_rst;
  assign beat_err  = data_ok && (HRESP == 2'b01);
  assign push      = data_ok && (HRESP != 2'b01);
  assign last      = push && (beats_r == (CNTR_WD+1)'(1));
  assign pop       = dmaTx2ahbm_rd && (count != '0) && !sw_rst;
  assign count_nxt = count + CW'(push) - CW'(pop);
  // A slot is only claimed when the next-cycle occupancy leaves room for one beat.
  assign room      = count_nxt < DEPTH_C;

  always_comb begin
    state_nxt = state;
    if (sw_rst) begin
      case (state)
        S_DATA:  state_nxt = HREADY ? S_IDLE : S_FLUSH;
        S_ADDR:  state_nxt = !HREADY ? S_ADDR : (abort_pend ? S_FLUSH : S_IDLE);
        S_FLUSH: state_nxt = HREADY ? S_IDLE : S_FLUSH;
        default: state_nxt = S_IDLE;
      endcase
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok && (dmaTx2ahbm_len != '0))
            state_nxt = room ? S_ADDR : S_WSPACE;
        end
        S_ADDR: begin
          if (HREADY) state_nxt = abort_pend ? S_FLUSH : S_DATA;
        end
        S_DATA: begin
          if (HREADY) begin
            if (beat_err || last) state_nxt = S_IDLE;
            else                  state_nxt = room ? S_ADDR : S_WSPACE;
          end
        end
        S_WSPACE: begin
          if (beats_r == '0) state_nxt = S_IDLE;
          else if (room)     state_nxt = S_ADDR;
        end
        S_FLUSH: begin
          if (HREADY) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge core_Clk or posedge uctl_reset) begin
    if (uctl_reset) begin
      state      <= S_IDLE;
      addr_r     <= '0;
      beats_r    <= '0;
      abort_pend <= 1'b0;
      zero_dn_r  <= 1'b0;
    end else begin
      state     <= state_nxt;
      zero_dn_r <= start_ok && (dmaTx2ahbm_len == '0);
      if (sw_rst) begin
        beats_r <= '0;
        // A stalled address phase must keep HADDR stable until the slave takes it.
        if ((state == S_ADDR) && !HREADY) begin
          abort_pend <= 1'b1;
        end else begin
          abort_pend <= 1'b0;
          addr_r     <= '0;
        end
      end else begin
        if (abort_pend && (state == S_ADDR) && HREADY) begin
          abort_pend <= 1'b0;
          addr_r     <= '0;
        end
        if (start_ok) begin
          addr_r  <= dmaTx2ahbm_sRdAddr & ~ADDR_SIZE'(3);
          beats_r <= beats_len;
        end else if (push) begin
          beats_r <= beats_r - (CNTR_WD+1)'(1);
          addr_r  <= addr_r + ADDR_SIZE'(4);
        end else if (beat_err) begin
          beats_r <= '0;
        end
      end
    end
  end

  always_ff @(posedge core_Clk or posedge uctl_reset) begin
    if (uctl_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (sw_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
    end
  end

  always_ff @(posedge core_Clk) begin
    if (push) mem[wr_ptr] <= HRDATA;
  end

  assign ahbm2dmaTx_ready  = (count != '0);
  assign ahbm2dmaTx_wrData = (count != '0) ? mem[rd_ptr] : '0;
  assign ahbm2dmaTx_dataDn = zero_dn_r | last | beat_err;
  assign ahbm2dmaTx_err    = beat_err;

  assign HADDR     = addr_r;
  assign HTRANS    = (state == S_ADDR) ? 2'b10 : 2'b00;
  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HWRITE    = 1'b0;
  assign fsm_state = state;

endmodule

// File: doc/uctl_ahbm_rd_fetch.md
# uctl_ahbm_rd_fetch

AHB-Lite read master with a small prefetch FIFO feeding the DMA Tx stage. It accepts a read request (system address, byte length) from the DMA Tx engine and issues word-sized SINGLE reads on AHB. Returned words are buffered in a show-ahead FIFO, which the DMA Tx engine pops word by word into local endpoint memory.

## Interface
- CNTR_WD, 20, byte-length width
- DATA_SIZE, 32, data width (fixed at 32)
- ADDR_SIZE, 32, address width
- FIFO_DEPTH, 4, FIFO words (power of 2, ≥2)

Ports:
- core_Clk  in  1  single clock for the block and the AHB bus
- uctl_reset  in  1  asynchronous, active-high reset
- sw_rst  in  1  synchronous soft reset
- dmaTx2ahbm_sRdAddr  in  ADDR_SIZE  system read start address
- dmaTx2ahbm_len  in  CNTR_WD  transfer length in bytes
- dmaTx2ahbm_stransEn  in  1  start pulse
- dmaTx2ahbm_sRdWr  in  1  0 = read; request is ignored when 1
- dmaTx2ahbm_rd  in  1  FIFO pop
- ahbm2dmaTx_ready  out  1  FIFO not empty
- ahbm2dmaTx_wrData  out  DATA_SIZE  FIFO head word
- ahbm2dmaTx_dataDn  out  1  pulse when the final beat is captured
- ahbm2dmaTx_err  out  1  pulse when an AHB ERROR response aborts the transfer
- HADDR  out  ADDR_SIZE  AHB address
- HTRANS  out  2  IDLE = 00, NONSEQ = 10
- HSIZE  out  3  constant 3'b010
- HBURST  out  3  constant 3'b000 (SINGLE)
- HWRITE  out  1  constant 0
- HREADY  in  1  AHB ready
- HRDATA  in  DATA_SIZE  AHB read data
- HRESP  in  2  00 = OKAY, 01 = ERROR

## Operation
- **Capture.** In IDLE, stransEn=1 with sRdWr=0 latches:
  - addr_r = {sRdAddr[ADDR_SIZE-1:2], 2'b00}
  - beats_r = ceil(len/4), i.e. (len+3)>>2 at width CNTR_WD+1
- **Zero length.** If len=0, dataDn pulses in the next cycle. No AHB traffic, FSM stays in IDLE.
- **Ignored starts.** stransEn is ignored outside IDLE.
- **FSM states:**
  - IDLE: wait for a start.
  - ADDR: HTRANS=NONSEQ, HADDR=addr_r. On HREADY=1, go to DATA.
  - DATA: HTRANS=IDLE. On HREADY=1:
    - HRESP=OKAY: push HRDATA, decrement beats_r, add 4 to addr_r (wrapping modulo 2^ADDR_SIZE).
    - HRESP=ERROR: abort.
  - WSPACE: wait for a free FIFO slot.
  - FLUSH: wait for HREADY=1, discard the data, go to IDLE.
- **Issue rule.** ADDR is entered only when beats_r≠0 and FIFO count < FIFO_DEPTH. Otherwise the FSM waits in WSPACE. Only one transfer is ever outstanding, so an accepted beat never overflows the FIFO.
- **Last beat.** When the beat with beats_r=1 is pushed, dataDn pulses in that same cycle and the FSM goes to IDLE. FIFO contents remain poppable afterwards.
- **Error.** On ERROR, drop the beat and pulse err and dataDn together. Clear beats_r, go to IDLE. The FIFO is not flushed.
- **FIFO behaviour.**
  - Show-ahead: wrData is the head word, 0 when empty.
  - ready = count≠0.
  - A pop while empty is ignored.
  - Simultaneous push and pop leaves count unchanged.
- **sw_rst.**
  - Clears the FIFO, beats_r, addr_r, err and dataDn.
  - From DATA with HREADY=0: go to FLUSH so the bus phase completes legally.
  - From ADDR with HREADY=0: hold NONSEQ until HREADY=1, then go to FLUSH.
  - Otherwise: go to IDLE.
- **uctl_reset.** Returns everything to the reset state immediately. HTRANS becomes IDLE.

## Timing
- **Reset values:** HTRANS=00, HADDR=0, ready=0, wrData=0, dataDn=0, err=0, FSM=IDLE. HSIZE, HBURST and HWRITE are constant.
- **Start to address phase:** stransEn at cycle N puts NONSEQ on the bus at cycle N+1.
- **Throughput:** with HREADY=1 throughout, one beat per 2 cycles. For each beat:
  - NONSEQ at cycle k.
  - Data sampled at k+1.
  - ready=1 from k+2, if the FIFO was empty.
  - The next NONSEQ follows at k+2.
- **Wait states:** each HREADY=0 cycle in ADDR or DATA extends that state by one cycle.
- **Output style:**
  - dataDn and err are Mealy outputs from DATA (combinational on HREADY/HRESP), except the len=0 pulse, which is registered.
  - All AHB outputs are registered or decoded from state only.
- **FIFO latency:** a pop at cycle k presents the next word at k+1.

## Test plan
- **Basic read.** sRdAddr=0x1000_0003, len=10, HREADY=1.
  - Expected: 3 NONSEQ reads at 0x1000_0000, 0x1000_0004 and 0x1000_0008, each 2 cycles apart.
  - Expected: dataDn with the 3rd beat; 3 words popped in order.
- **Zero length.** len=0.
  - Expected: dataDn exactly 1 cycle after stransEn; HTRANS stays 00.
- **Backpressure.** FIFO_DEPTH=4, len=32, no pops.
  - Expected: 4 reads, then the FSM holds in WSPACE with HTRANS=00 and ready=1.
  - Then pop once: the 5th NONSEQ appears within 1 cycle.
- **Wait states and error.** Random HREADY=0 insertion, then HRESP=01 on the 2nd beat of len=16.
  - Expected: only 1 word stored; err and dataDn pulse together; no further NONSEQ.
- **Soft reset mid-transfer.** sw_rst in DATA with HREADY=0.
  - Expected: FSM goes to FLUSH; the data is discarded when HREADY=1; ready=0; IDLE follows.
  - Expected: a new start then works normally.
- **Async reset and ignored start.** Assert uctl_reset mid-transfer.
  - Expected: all outputs take their reset values immediately.
  - Also: stransEn during ADDR or DATA, and stransEn with sRdWr=1, produce no effect.
